// File: rtl/syn_timer_pkg.sv
// syn_timer_pkg: register map, control bit positions and control struct shared by the timer.
package syn_timer_pkg;
  localparam logic [2:0] REG_STATUS   = 3'd0;
  localparam logic [2:0] REG_CONTROL  = 3'd1;
  localparam logic [2:0] REG_PERIOD   = 3'd2;
  localparam logic [2:0] REG_PRESCALE = 3'd3;
  localparam logic [2:0] REG_SNAP     = 3'd4;
  localparam logic [2:0] REG_COUNT    = 3'd5;
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;
  localparam int CTL_CHAIN = 4;
  typedef struct packed {
    logic chain;
    logic stop;
    logic start;
    logic cont;
    logic ito;
  } ctrl_t;
endpackage

// File: rtl/syn_timer_chan.sv
// syn_timer_chan: one timer channel with prescaler, down-counter, TO/RUN flags, snapshot and tick pulse.
module syn_timer_chan
  import syn_timer_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 16,
  parameter int unsigned RST_PERIOD = 99999,
  parameter bit          CHAINABLE  = 1'b0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_status,
  input  logic        wr_ctrl,
  input  logic        wr_period,
  input  logic        wr_prescale,
  input  logic        wr_snap,
  input  logic [31:0] wdata,
  input  logic        chain_tick,
  output logic [31:0] status_rd,
  output logic [31:0] ctrl_rd,
  output logic [31:0] period_rd,
  output logic [31:0] prescale_rd,
  output logic [31:0] snap_rd,
  output logic [31:0] count_rd,
  output logic        evt,
  output logic        tick_out,
  output logic        irq
);
  ctrl_t            ctrl_q, ctrl_d;
  logic [CNT_W-1:0] period_q, period_d, cnt_q, cnt_d, snap_q, snap_d;
  logic [PRE_W-1:0] prescale_q, prescale_d, pre_q, pre_d;
  logic             to_q, to_d, run_q, run_d, reload_q, reload_d, tick_q, tick_d;
  logic             start, stop, tick;

  always_comb begin
    start      = wr_ctrl & wdata[CTL_START];
    stop       = wr_ctrl & wdata[CTL_STOP] & ~start;
    tick       = (CHAINABLE && ctrl_q.chain) ? chain_tick & run_q : run_q & (pre_q == '0);
    evt        = tick & (cnt_q == '0);
    ctrl_d     = wr_ctrl ? ctrl_t'(wdata[4:0]) : ctrl_q;
    period_d   = wr_period ? wdata[CNT_W-1:0] : period_q;
    prescale_d = wr_prescale ? wdata[PRE_W-1:0] : prescale_q;
    snap_d     = wr_snap ? cnt_q : snap_q;
    reload_d   = wr_period;
    to_d       = evt | (to_q & ~wr_status);
    tick_d     = evt;
    pre_d      = !run_q ? pre_q : (pre_q == '0) ? prescale_q : pre_q - PRE_W'(1);
    cnt_d      = evt ? period_q : tick ? cnt_q - CNT_W'(1) : cnt_q;
    run_d      = evt ? ctrl_q.cont : run_q;
    if (start) begin
      run_d = 1'b1;
      if (!run_q) begin
        cnt_d = period_q;
        pre_d = prescale_q;
      end
    end
    if (stop) run_d = 1'b0;
    // A PERIOD write reloads one cycle later and takes precedence over any START.
    if (reload_q) begin
      cnt_d = period_q;
      pre_d = prescale_q;
      run_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q     <= '0;
      period_q   <= CNT_W'(RST_PERIOD);
      cnt_q      <= CNT_W'(RST_PERIOD);
      snap_q     <= '0;
      prescale_q <= '0;
      pre_q      <= '0;
      to_q       <= 1'b0;
      run_q      <= 1'b0;
      reload_q   <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      snap_q     <= snap_d;
      prescale_q <= prescale_d;
      pre_q      <= pre_d;
      to_q       <= to_d;
      run_q      <= run_d;
      reload_q   <= reload_d;
      tick_q     <= tick_d;
    end
  end

  assign status_rd   = {30'd0, run_q, to_q};
  assign ctrl_rd     = {27'd0, ctrl_q};
  assign period_rd   = 32'(period_q);
  assign prescale_rd = 32'(prescale_q);
  assign snap_rd     = 32'(snap_q);
  assign count_rd    = 32'(cnt_q);
  assign tick_out    = tick_q;
  assign irq         = to_q & ctrl_q.ito;
endmodule

// File: rtl/syn_multi_timer.sv
// syn_multi_timer: NUM_CH interval timers behind an Avalon-MM slave with registered read data.
module syn_multi_timer
  import syn_timer_pkg::*;
#(
  parameter int          NUM_CH     = 4,
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 16,
  parameter int unsigned RST_PERIOD = 99999
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [$clog2(NUM_CH)+2:0]    address,
  input  logic                         chipselect,
  input  logic                         read,
  input  logic                         write_n,
  input  logic [31:0]                  writedata,
  output logic [31:0]                  readdata,
  output logic [NUM_CH-1:0]            irq,
  output logic                         irq_any,
  output logic [NUM_CH-1:0]            tick_out
);
  localparam int AW = $clog2(NUM_CH) + 3;

  logic [AW-1:0]     ch_idx;
  logic [2:0]        reg_off;
  logic              wr;
  logic [NUM_CH-1:0] evt, chain_in;
  logic [31:0]       rd_val [NUM_CH];
  logic [31:0]       readdata_d, readdata_q;

  assign wr       = chipselect & ~write_n;
  assign ch_idx   = address >> 3;
  assign reg_off  = address[2:0];
  // Chaining uses the upstream combinational timeout so each stage adds no latency.
  assign chain_in = evt << 1;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic        sel;
    logic [31:0] st, ct, pe, ps, sn, co;
    assign sel = wr && (ch_idx == AW'(c));
    syn_timer_chan #(
      .CNT_W(CNT_W), .PRE_W(PRE_W), .RST_PERIOD(RST_PERIOD), .CHAINABLE(c > 0)
    ) u_chan (
      .clk(clk),
      .reset_n(reset_n),
      .wr_status(sel && reg_off == REG_STATUS),
      .wr_ctrl(sel && reg_off == REG_CONTROL),
      .wr_period(sel && reg_off == REG_PERIOD),
      .wr_prescale(sel && reg_off == REG_PRESCALE),
      .wr_snap(sel && reg_off == REG_SNAP),
      .wdata(writedata),
      .chain_tick(chain_in[c]),
      .status_rd(st),
      .ctrl_rd(ct),
      .period_rd(pe),
      .prescale_rd(ps),
      .snap_rd(sn),
      .count_rd(co),
      .evt(evt[c]),
      .tick_out(tick_out[c]),
      .irq(irq[c])
    );
    assign rd_val[c] = reg_off == REG_STATUS   ? st :
                       reg_off == REG_CONTROL  ? ct :
                       reg_off == REG_PERIOD   ? pe :
                       reg_off == REG_PRESCALE ? ps :
                       reg_off == REG_SNAP     ? sn :
                       reg_off == REG_COUNT    ? co : 32'd0;
  end

  always_comb begin
    readdata_d = readdata_q;
    if (chipselect & read) begin
      readdata_d = '0;
      for (int i = 0; i < NUM_CH; i++)
        if (ch_idx == AW'(i)) readdata_d = rd_val[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq_any  = |irq;
endmodule

// File: tb/tb_syn_multi_timer.sv
// tb_syn_multi_timer: table-driven register checks plus directed timing sequences for the timer.
module tb_syn_multi_timer;
  localparam int NCH = 4;
  localparam int AW  = 5;
  localparam int ST = 0, CT = 1, PE = 2, PS = 3, SN = 4, CO = 5;

  logic            clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, read = 1'b0, write_n = 1'b1;
  logic [AW-1:0]   address = '0;
  logic [31:0]     writedata = '0;
  logic [31:0]     readdata;
  logic [NCH-1:0]  irq, tick_out;
  logic            irq_any;
  int              cyc = 0, n_cmp = 0, n_bad = 0;
  int              tq [NCH][$];

  typedef struct {
    bit          w;
    int          ch;
    int          rg;
    logic [31:0] d;
    logic [31:0] e;
  } vec_t;
  vec_t vec [18];

  always #5 clk = ~clk;

  syn_multi_timer #(.NUM_CH(NCH), .CNT_W(32), .PRE_W(16), .RST_PERIOD(99999)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .irq(irq), .irq_any(irq_any), .tick_out(tick_out)
  );

  // Records the index of the edge at which each timeout event happened.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int i = 0; i < NCH; i++)
      if (tick_out[i]) tq[i].push_back(cyc);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic wr(input int ch, input int rg, input logic [31:0] d);
    @(negedge clk);
    address = AW'(ch * 8 + rg); writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk); #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic rd(input int ch, input int rg, output logic [31:0] v);
    @(negedge clk);
    address = AW'(ch * 8 + rg); chipselect = 1'b1; read = 1'b1;
    @(posedge clk); #1;
    chipselect = 1'b0; read = 1'b0;
    v = readdata;
  endtask

  task automatic wait_n(input int ch, input int n, input int budget, input string nm);
    int b = 0;
    while (tq[ch].size() < n && b < budget) begin
      @(negedge clk);
      b++;
    end
    if (tq[ch].size() < n) begin
      n_cmp++; n_bad++;
      $display("FAIL %s: timed out with %0d ticks, expected %0d", nm, tq[ch].size(), n);
    end
  endtask

  initial begin
    logic [31:0] v;
    int s, b0, b1;
    vec[0]  = '{0, 0, CO, 0, 99999};
    vec[1]  = '{0, 0, ST, 0, 0};
    vec[2]  = '{0, 3, PE, 0, 99999};
    vec[3]  = '{0, 2, PS, 0, 0};
    vec[4]  = '{0, 1, CT, 0, 0};
    vec[5]  = '{0, 0, 6,  0, 0};
    vec[6]  = '{1, 2, PE, 32'h1234, 0};
    vec[7]  = '{1, 2, PS, 32'hABCDE, 0};
    vec[8]  = '{0, 2, PE, 0, 32'h1234};
    vec[9]  = '{0, 2, CO, 0, 32'h1234};
    vec[10] = '{0, 2, PS, 0, 32'hBCDE};
    vec[11] = '{1, 2, CT, 32'h10, 0};
    vec[12] = '{0, 2, CT, 0, 32'h10};
    vec[13] = '{1, 3, 7,  32'hFFFF, 0};
    vec[14] = '{0, 3, 7,  0, 0};
    vec[15] = '{0, 2, ST, 0, 0};
    vec[16] = '{1, 2, SN, 0, 0};
    vec[17] = '{0, 2, SN, 0, 32'h1234};

    repeat (3) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    chk("rst_readdata", readdata, 0);
    chk("rst_irq", 32'(irq), 0);
    repeat (1000) @(posedge clk);
    #1;
    chk("rst_no_ticks", 32'(tq[0].size() + tq[1].size() + tq[2].size() + tq[3].size()), 0);

    for (int i = 0; i < 18; i++) begin
      if (vec[i].w) wr(vec[i].ch, vec[i].rg, vec[i].d);
      else begin
        rd(vec[i].ch, vec[i].rg, v);
        chk($sformatf("vec%0d", i), v, vec[i].e);
      end
    end

    // Channel 0 continuous, period 10 cycles, irq enabled.
    b0 = tq[0].size();
    wr(0, PE, 9); wr(0, PS, 0); wr(0, CT, 32'h07);
    s = cyc;
    chk("ch0_irq_before", 32'(irq[0]), 0);
    wait_n(0, b0 + 1, 40, "ch0_first_wait");
    chk("ch0_first_time", 32'(tq[0][b0] - s), 10);
    chk("ch0_irq_set", 32'(irq[0]), 1);
    chk("ch0_irq_any", 32'(irq_any), 1);
    wr(0, ST, 0);
    chk("ch0_irq_clr", 32'(irq[0]), 0);
    wait_n(0, b0 + 3, 60, "ch0_more_wait");
    chk("ch0_interval1", 32'(tq[0][b0 + 1] - tq[0][b0]), 10);
    chk("ch0_interval2", 32'(tq[0][b0 + 2] - tq[0][b0 + 1]), 10);
    wr(0, CT, 32'h08);

    // Channel 1 one-shot with prescaler: (3+1)*(4+1) = 20 cycles.
    b1 = tq[1].size();
    wr(1, PE, 3); wr(1, PS, 4); wr(1, CT, 32'h04);
    s = cyc;
    wait_n(1, b1 + 1, 60, "pre_wait");
    chk("pre_time", 32'(tq[1][b1] - s), 20);
    repeat (50) @(posedge clk);
    #1;
    chk("pre_single", 32'(tq[1].size() - b1), 1);
    rd(1, ST, v); chk("pre_status", v, 32'h1);
    rd(1, CO, v); chk("pre_count", v, 3);

    // Chain: ch0 every 5 cycles, ch1 counts 3 upstream events.
    wr(1, PE, 2); wr(1, PS, 0); wr(1, CT, 32'h16);
    b0 = tq[0].size(); b1 = tq[1].size();
    wr(0, PE, 4); wr(0, PS, 0); wr(0, CT, 32'h06);
    s = cyc;
    wait_n(1, b1 + 3, 80, "chain_wait");
    chk("chain_first", 32'(tq[1][b1] - s), 15);
    chk("chain_int1", 32'(tq[1][b1 + 1] - tq[1][b1]), 15);
    chk("chain_int2", 32'(tq[1][b1 + 2] - tq[1][b1 + 1]), 15);
    chk("chain_zero_lat", 32'(tq[1][b1]), 32'(tq[0][b0 + 2]));
    wr(1, CT, 32'h08); wr(0, CT, 32'h08);

    // STATUS write on the timeout edge: set wins.
    b0 = tq[0].size();
    wr(0, PE, 9); wr(0, PS, 0); wr(0, CT, 32'h07);
    s = cyc;
    repeat (9) @(posedge clk);
    wr(0, ST, 0);
    rd(0, ST, v); chk("to_set_wins", v, 32'h3);
    chk("to_evt_time", 32'(tq[0][b0] - s), 10);
    wr(0, ST, 0);
    rd(0, ST, v); chk("to_clear", v, 32'h2);

    // START+STOP, PERIOD write while running, reload beats START.
    wr(0, CT, 32'h08);
    rd(0, ST, v); chk("stop_run", v & 32'h2, 0);
    wr(0, CT, 32'h0C);
    rd(0, ST, v); chk("start_stop_run", v & 32'h2, 32'h2);
    wr(0, PE, 50);
    @(posedge clk);
    rd(0, ST, v); chk("pwr_run", v & 32'h2, 0);
    rd(0, CO, v); chk("pwr_count", v, 50);
    wr(0, PE, 20); wr(0, CT, 32'h04);
    rd(0, ST, v); chk("reload_beats_start", v & 32'h2, 0);
    rd(0, CO, v); chk("reload_count", v, 20);

    // Snapshot while counting.
    wr(0, PE, 200); wr(0, PS, 0); wr(0, CT, 32'h06);
    repeat (29) @(posedge clk);
    wr(0, SN, 32'hDEAD);
    rd(0, SN, v); chk("snap_val", v, 171);
    rd(0, CO, v); chk("snap_live1", v, 169);
    rd(0, CO, v); chk("snap_live2", v, 168);
    rd(0, 6, v);  chk("off6_zero", v, 0);

    // Reset in the middle of a count.
    @(negedge clk) reset_n = 1'b0;
    #1;
    chk("mid_rst_readdata", readdata, 0);
    chk("mid_rst_tick", 32'(tick_out), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    rd(0, CO, v); chk("mid_rst_count", v, 99999);
    rd(0, ST, v); chk("mid_rst_status", v, 0);
    rd(0, PE, v); chk("mid_rst_period", v, 99999);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
